// File: rtl/integral_image_gen.sv
// integral_image_gen: streaming summed-area table generator, one pixel per cycle,
// emitting S(x,y) at linear address y*width + x through a single output register.
module integral_image_gen #(
    parameter int MAX_W  = 512,
    parameter int MAX_H  = 512,
    parameter int PIX_W  = 8,
    parameter int SUM_W  = 32,
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        width,
    input  logic [9:0]        height,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);
    localparam int XW = $clog2(MAX_W + 1);
    localparam int YW = $clog2(MAX_H + 1);
    localparam int XI = $clog2(MAX_W);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_n;

    logic [XW-1:0]     w, x, w_in;
    logic [YW-1:0]     h, y, h_in;
    logic [ADDR_W-1:0] addr;
    logic [SUM_W-1:0]  row_acc, acc_n, above, sum;
    logic [SUM_W-1:0]  rowbuf [MAX_W];
    logic              accept, x_last, frame_end;

    assign w_in      = (32'(width) > MAX_W) ? XW'(MAX_W) : XW'(width);
    assign h_in      = (32'(height) > MAX_H) ? YW'(MAX_H) : YW'(height);
    assign in_ready  = state == RUN && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign x_last    = x == w - XW'(1);
    assign frame_end = x_last && y == h - YW'(1);
    // rowbuf holds the previous row's sums; read before this cycle's write
    assign above     = rowbuf[x[XI-1:0]];
    assign acc_n     = (x == '0 ? '0 : row_acc) + SUM_W'(in_pixel);
    assign sum       = acc_n + (y == '0 ? '0 : above);
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (width == '0 || height == '0) ? DONE : RUN;
            RUN:     if (accept && frame_end) state_n = FLUSH;
            FLUSH:   if (out_ready) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) rowbuf[x[XI-1:0]] <= sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            w         <= '0;
            h         <= '0;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            row_acc   <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_addr  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                w       <= w_in;
                h       <= h_in;
                x       <= '0;
                y       <= '0;
                addr    <= '0;
                row_acc <= '0;
            end
            if (accept) begin
                row_acc  <= acc_n;
                x        <= x_last ? '0 : x + XW'(1);
                y        <= x_last ? y + YW'(1) : y;
                addr     <= addr + ADDR_W'(1);
                out_sum  <= sum;
                out_addr <= addr;
            end
            out_valid <= accept ? 1'b1 : (out_ready ? 1'b0 : out_valid);
        end
    end
endmodule

// File: tb/tb_integral_image_gen.sv
// tb_integral_image_gen: directed frames with hand-computed summed-area values.
module tb_integral_image_gen;
    logic        clk = 1'b0;
    logic        reset, start, in_valid, out_ready;
    logic [9:0]  width, height;
    logic [7:0]  in_pixel;
    logic        in_ready, out_valid, busy, done;
    logic [31:0] out_sum;
    logic [17:0] out_addr;
    int checks = 0, errors = 0, done_cnt = 0, cyc;
    int pix_q[$], exp_q[$];

    integral_image_gen dut (
        .clk(clk), .reset(reset), .start(start), .width(width), .height(height),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_addr(out_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h);
        width  = 10'(w);
        height = 10'(h);
        start  = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic load(input int n, input int p0, input int p1, input int p2, input int p3);
        pix_q.delete();
        exp_q.delete();
        pix_q.push_back(p0);
        if (n > 1) pix_q.push_back(p1);
        if (n > 2) pix_q.push_back(p2);
        if (n > 3) pix_q.push_back(p3);
    endtask

    // drives pix_q, checks every handshake against exp_q, then the done pulse
    task automatic stream(input string tag, input int stall_idx, input int stall_len,
                          input int restart_at, input int budget, output int cycles);
        int pi = 0, k = 0, stall = 0, d0 = done_cnt;
        cycles = 0;
        while (k < exp_q.size() && cycles < budget) begin
            in_valid  = pi < pix_q.size();
            in_pixel  = in_valid ? 8'(pix_q[pi]) : 8'd0;
            out_ready = !(k == stall_idx && stall < stall_len);
            if (cycles == restart_at) begin
                start  = 1'b1;
                width  = 10'd2;
                height = 10'd2;
            end else start = 1'b0;
            #1;
            if (!out_ready && out_valid) begin
                check({tag, "_hold_sum"}, out_sum, exp_q[k]);
                check({tag, "_hold_addr"}, out_addr, k);
                check({tag, "_stall_in_ready"}, in_ready, 0);
                stall++;
            end
            if (out_valid && out_ready) begin
                check({tag, "_sum"}, out_sum, exp_q[k]);
                check({tag, "_addr"}, out_addr, k);
                k++;
            end
            if (in_valid && in_ready) pi++;
            cycle();
            cycles++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        check({tag, "_outputs"}, k, exp_q.size());
        check({tag, "_done"}, done, 1);
        cycle();
        check({tag, "_done_clear"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        width = '0; height = '0; in_pixel = '0;
        cycle();
        cycle();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        cycle();

        // 3x3 all ones, full throughput
        pix_q.delete();
        exp_q = '{1, 2, 3, 2, 4, 6, 3, 6, 9};
        for (int i = 0; i < 9; i++) pix_q.push_back(1);
        do_start(3, 3);
        check("s3_busy", busy, 1);
        stream("s3", -1, 0, -1, 100, cyc);
        check("s3_cycles", cyc, 10);

        // 2x2 with a 3-cycle stall on the second output
        load(4, 1, 2, 3, 4);
        exp_q = '{1, 3, 4, 10};
        do_start(2, 2);
        stream("stall", 1, 3, -1, 100, cyc);

        // zero width
        do_start(0, 5);
        check("zero_done", done, 1);
        check("zero_in_ready", in_ready, 0);
        check("zero_out_valid", out_valid, 0);
        cycle();
        check("zero_done_clear", done, 0);
        check("zero_busy", busy, 0);
        check("zero_out_valid2", out_valid, 0);

        // mid-frame reset then a clean 2x2 frame
        do_start(4, 4);
        in_valid = 1'b1; in_pixel = 8'd5; out_ready = 1'b1;
        repeat (6) cycle();
        check("mid_out_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_sum", out_sum, 0);
        check("mid_rst_out_addr", out_addr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        cycle();
        load(4, 1, 2, 3, 4);
        exp_q = '{1, 3, 4, 10};
        do_start(2, 2);
        stream("after_rst", -1, 0, -1, 100, cyc);

        // start pulsed mid-frame with other dimensions is ignored
        pix_q.delete();
        exp_q = '{1, 2, 3, 2, 4, 6, 3, 6, 9};
        for (int i = 0; i < 9; i++) pix_q.push_back(1);
        do_start(3, 3);
        stream("restart", -1, 0, 3, 100, cyc);
        repeat (3) cycle();
        check("restart_stay_idle", busy, 0);

        // oversize width clamps to 512; full-width row buffer with max pixels
        pix_q.delete();
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            pix_q.push_back(255);
            exp_q.push_back(255 * (i % 512 + 1) * (i / 512 + 1));
        end
        do_start(600, 2);
        stream("clamp", -1, 0, -1, 3000, cyc);
        check("clamp_last_sum", out_sum, 261120);
        check("clamp_last_addr", out_addr, 1023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
